fc_layer: RTL and testbench
===========================

// Module: fc_layer
// PURPOSE
// - Parametrised fully-connected (dense) layer for the 1D-CNN datapath; successor to hard-wired per-neuron nets.
// - Accepts one NUM_INPUTS vector, computes NUM_OUTPUTS neurons serially on one shared multiplier, applies activation, presents result vector.
// - Weights/biases are run-time loadable through a config write port; layers chain by valid/ready.
// PARAMETERS
// - NUM_INPUTS   2           input vector length (>=1)
// - NUM_OUTPUTS  2           neuron count / output vector length (>=1)
// - DATA_WIDTH   DATA_WIDTH  signed fixed-point word width (cnn1d_pkg default 12)
// - FRAC_BITS    FRAC_BITS   fractional bits (cnn1d_pkg default 9; 1.0 = 12'h200)
// - ACTIVATION   ACT_RELU    act_t: ACT_NONE | ACT_RELU
// PORTS
// - clk            in   1                      clock
// - rst            in   1                      synchronous reset, active-low (rst==0 resets)
// - fc_ready_in    out  1                      layer can accept an input vector
// - fc_valid_in    in   1                      input vector valid
// - fc_data_in     in   DATA_WIDTH x NUM_INPUTS   unpacked [0:NUM_INPUTS-1], signed
// - fc_ready_out   in   1                      downstream accepts output vector
// - fc_valid_out   out  1                      output vector valid
// - fc_data_out    out  DATA_WIDTH x NUM_OUTPUTS  unpacked [0:NUM_OUTPUTS-1], signed
// - cfg_wr_en      in   1                      coefficient write strobe
// - cfg_addr       in   $clog2(NI*NO+NO)       weight j*NI+i -> W[j][i]; NI*NO+j -> bias[j]
// - cfg_data       in   DATA_WIDTH             coefficient value, signed
// - cfg_ready      out  1                      high in S_IDLE only; writes honoured only then
// BEHAVIOUR
// - FSM S_IDLE -> S_MAC -> S_OUT -> S_IDLE. fc_ready_in = cfg_ready = (state==S_IDLE).
// - S_IDLE: on fc_valid_in&&fc_ready_in capture fc_data_in into input regs, clear i,j, go S_MAC.
// - S_MAC: one product/cycle, i inner (0..NI-1), j outer (0..NO-1).
//   acc <= (i==0 ? sext(bias[j])<<<FRAC_BITS : acc) + x[i]*W[j][i]; full-precision signed.
//   ACC_W = 2*DATA_WIDTH + $clog2(NUM_INPUTS+1); no overflow possible inside acc.
//   On i==NI-1: r = (acc+prod)>>>FRAC_BITS (arith, truncate toward -inf); saturate to
//   [-2^(DW-1), 2^(DW-1)-1]; ReLU then clamps negatives to 0; write to fc_data_out[j].
//   After j==NO-1,i==NI-1 go S_OUT. S_MAC lasts exactly NI*NO cycles.
// - S_OUT: fc_valid_out=1, fc_data_out stable until fc_ready_out; on handshake go S_IDLE.
//   No same-cycle re-accept: one-cycle bubble between handshake-out and next handshake-in.
// - Latency: input handshake at cycle T -> fc_valid_out high at T+NI*NO+1.
// - fc_data_out registers hold last result after S_OUT; only meaningful while fc_valid_out.
// - Config: write in S_IDLE with in-range addr updates coefficient next cycle; writes while
//   busy or with addr >= NI*NO+NO silently dropped. Same-cycle cfg write + input accept:
//   write lands, vector computed with new coefficient.
// - Reset (any state, incl. mid-S_MAC/S_OUT): state S_IDLE, fc_valid_out=0, fc_data_out=0,
//   acc=0, counters=0, all W/bias=0; fc_ready_in=cfg_ready=1 first cycle after reset release.
// STRUCTURE
// - cnn1d_pkg: add FRAC_BITS, act_t enum (ACT_NONE, ACT_RELU), fc_state_t (S_IDLE,S_MAC,S_OUT),
//   function sat_shift(acc) -> DATA_WIDTH.
// - Sub-module fc_mac: multiply-accumulate + shift/saturate/activation (combinational result,
//   registered acc); fc_layer owns FSM, counters, coefficient regfile, input/output regs.
// TESTING (NI=2, NO=2, DW=12, FRAC=9, ReLU unless noted)
// - W all 12'h200, bias {12'h000,12'hE00}, x={12'h200,12'h200} -> out {12'h400,12'h200}, valid at T+5.
// - Same W, x={12'h000,12'h000} -> out {12'h000,12'h000} (bias -1.0 clamped by ReLU); ACT_NONE -> {12'h000,12'hE00}.
// - W all 12'h400, bias 0, x={12'h400,12'h400} -> acc 8.0 saturates -> {12'h7FF,12'h7FF}; x negated, ACT_NONE -> 12'h800.
// - Hold fc_ready_out=0 for 10 cycles in S_OUT -> fc_valid_out=1, data constant, fc_ready_in=0, cfg writes dropped.
// - cfg write addr 6 (out of range) and writes during S_MAC -> coefficients unchanged; readback via next result.
// - Assert rst=0 at 2nd S_MAC cycle -> next cycle valid_out=0, ready_in=1; re-run vector 1 after reload -> {12'h400,12'h200}.

Source files
------------

// File: rtl/cnn1d_pkg.sv
// Shared types, fixed-point defaults and the shift/saturate helper for the 1D-CNN datapath.
package cnn1d_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int FRAC_BITS  = 9;
  // Working width of the saturation helper; wide enough for any accumulator in this datapath.
  localparam int SAT_W      = 64;

  typedef enum logic [0:0] {
    ACT_NONE = 1'b0,
    ACT_RELU = 1'b1
  } act_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MAC  = 2'b01,
    S_OUT  = 2'b10
  } fc_state_t;

  // Arithmetic right shift by fb (floor toward -inf), then clamp into a signed dw-bit range.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      dw,
    input int                      fb
  );
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    r  = acc >>> fb;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) begin
      sat_shift = hi;
    end else if (r < lo) begin
      sat_shift = lo;
    end else begin
      sat_shift = r;
    end
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Shared multiply-accumulate for one neuron at a time: registered accumulator, combinational
// rescaled/saturated/activated result of the running sum.
module fc_mac
  import cnn1d_pkg::act_t, cnn1d_pkg::ACT_RELU, cnn1d_pkg::SAT_W, cnn1d_pkg::sat_shift;
#(
  parameter int   NUM_INPUTS = 2,
  parameter int   DATA_WIDTH = cnn1d_pkg::DATA_WIDTH,
  parameter int   FRAC_BITS  = cnn1d_pkg::FRAC_BITS,
  parameter act_t ACTIVATION = ACT_RELU
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic                         first_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  logic signed [DATA_WIDTH-1:0] w_i,
  input  logic signed [DATA_WIDTH-1:0] bias_i,
  output logic signed [DATA_WIDTH-1:0] result_o
);

  // Headroom bits let NUM_INPUTS full-scale products plus the bias sum without wrapping.
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(NUM_INPUTS + 1);

  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic signed [ACC_W-1:0]        prod_ext_s;
  logic signed [ACC_W-1:0]        bias_ext_s;
  logic signed [ACC_W-1:0]        sum_s;
  logic signed [SAT_W-1:0]        wide_s;
  logic signed [DATA_WIDTH-1:0]   sat_s;
  logic signed [ACC_W-1:0]        acc_q;
  logic signed [ACC_W-1:0]        acc_d;

  assign prod_s     = x_i * w_i;
  assign prod_ext_s = {{(ACC_W - 2*DATA_WIDTH){prod_s[2*DATA_WIDTH-1]}}, prod_s};
  // Bias is Q(FRAC_BITS); products are Q(2*FRAC_BITS), so align the bias before adding.
  assign bias_ext_s = {{(ACC_W - DATA_WIDTH){bias_i[DATA_WIDTH-1]}}, bias_i} <<< FRAC_BITS;

  // Running sum restarts from the aligned bias on the first input of each neuron.
  always_comb begin
    sum_s = '0;
    acc_d = acc_q;
    if (first_i) begin
      sum_s = bias_ext_s + prod_ext_s;
    end else begin
      sum_s = acc_q + prod_ext_s;
    end
    if (en_i) begin
      acc_d = sum_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Rescale, saturate and apply the activation to the sum including the current product.
  always_comb begin
    wide_s   = {{(SAT_W - ACC_W){sum_s[ACC_W-1]}}, sum_s};
    sat_s    = DATA_WIDTH'(sat_shift(wide_s, DATA_WIDTH, FRAC_BITS));
    result_o = sat_s;
    if ((ACTIVATION == ACT_RELU) && sat_s[DATA_WIDTH-1]) begin
      result_o = '0;
    end else begin
      result_o = sat_s;
    end
  end

  // Accumulator register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected layer: serial neuron evaluation on one shared MAC, run-time loadable
// coefficients, valid/ready on both vector sides.
module fc_layer
  import cnn1d_pkg::act_t, cnn1d_pkg::ACT_RELU, cnn1d_pkg::fc_state_t,
         cnn1d_pkg::S_IDLE, cnn1d_pkg::S_MAC, cnn1d_pkg::S_OUT;
#(
  parameter int   NUM_INPUTS  = 2,
  parameter int   NUM_OUTPUTS = 2,
  parameter int   DATA_WIDTH  = cnn1d_pkg::DATA_WIDTH,
  parameter int   FRAC_BITS   = cnn1d_pkg::FRAC_BITS,
  parameter act_t ACTIVATION  = ACT_RELU,
  localparam int  NCOEF       = NUM_INPUTS * NUM_OUTPUTS + NUM_OUTPUTS,
  localparam int  ADDR_W      = $clog2(NCOEF)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         fc_ready_in,
  input  logic                         fc_valid_in,
  input  logic signed [DATA_WIDTH-1:0] fc_data_in [0:NUM_INPUTS-1],
  input  logic                         fc_ready_out,
  output logic                         fc_valid_out,
  output logic signed [DATA_WIDTH-1:0] fc_data_out [0:NUM_OUTPUTS-1],
  input  logic                         cfg_wr_en,
  input  logic [ADDR_W-1:0]            cfg_addr,
  input  logic signed [DATA_WIDTH-1:0] cfg_data,
  output logic                         cfg_ready
);

  localparam int IW = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
  localparam int JW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam logic [IW-1:0]   I_LAST  = IW'(NUM_INPUTS - 1);
  localparam logic [JW-1:0]   J_LAST  = JW'(NUM_OUTPUTS - 1);
  localparam logic [ADDR_W:0] NCOEF_L = (ADDR_W + 1)'(NCOEF);

  fc_state_t                    state_q, state_d;
  logic [IW-1:0]                i_q, i_d;
  logic [JW-1:0]                j_q, j_d;
  logic                         valid_q;
  logic signed [DATA_WIDTH-1:0] x_q    [0:NUM_INPUTS-1];
  logic signed [DATA_WIDTH-1:0] coef_q [0:NCOEF-1];
  logic signed [DATA_WIDTH-1:0] dout_q [0:NUM_OUTPUTS-1];
  logic                         idle_s;
  logic                         accept_s;
  logic                         cfg_we_s;
  logic                         last_i_s;
  logic [ADDR_W-1:0]            widx_s;
  logic [ADDR_W-1:0]            bidx_s;
  logic signed [DATA_WIDTH-1:0] mac_result_s;

  assign idle_s       = (state_q == S_IDLE);
  assign accept_s     = idle_s && fc_valid_in;
  assign cfg_we_s     = idle_s && cfg_wr_en && ({1'b0, cfg_addr} < NCOEF_L);
  assign last_i_s     = (i_q == I_LAST);
  assign widx_s       = ADDR_W'(j_q) * ADDR_W'(NUM_INPUTS) + ADDR_W'(i_q);
  assign bidx_s       = ADDR_W'(NUM_INPUTS * NUM_OUTPUTS) + ADDR_W'(j_q);
  assign fc_ready_in  = idle_s;
  assign cfg_ready    = idle_s;
  assign fc_valid_out = valid_q;
  assign fc_data_out  = dout_q;

  fc_mac #(
    .NUM_INPUTS (NUM_INPUTS),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACTIVATION (ACTIVATION)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q == S_MAC),
    .first_i  (i_q == '0),
    .x_i      (x_q[i_q]),
    .w_i      (coef_q[widx_s]),
    .bias_i   (coef_q[bidx_s]),
    .result_o (mac_result_s)
  );

  // Next-state and loop-counter logic: i walks inputs, j walks neurons.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      S_IDLE: begin
        if (fc_valid_in) begin
          state_d = S_MAC;
          i_d     = '0;
          j_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        if (last_i_s) begin
          i_d = '0;
          if (j_q == J_LAST) begin
            state_d = S_OUT;
            j_d     = '0;
          end else begin
            j_d = j_q + JW'(1);
          end
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_OUT: begin
        if (fc_ready_out) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
        i_d     = '0;
        j_d     = '0;
      end
    endcase
  end

  // State, counters and output-valid registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      valid_q <= (state_d == S_OUT);
    end
  end

  // Input vector capture on the accepting handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_INPUTS; k++) x_q[k] <= '0;
    end else if (accept_s) begin
      for (int k = 0; k < NUM_INPUTS; k++) x_q[k] <= fc_data_in[k];
    end
  end

  // Coefficient regfile: weights then biases, writable only while idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NCOEF; k++) coef_q[k] <= '0;
    end else if (cfg_we_s) begin
      coef_q[cfg_addr] <= cfg_data;
    end
  end

  // Result registers: each neuron lands when its last product is summed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_OUTPUTS; k++) dout_q[k] <= '0;
    end else if ((state_q == S_MAC) && last_i_s) begin
      dout_q[j_q] <= mac_result_s;
    end
  end

endmodule

// File: tb/tb_fc_layer.sv
// Directed bench for fc_layer: a ReLU and a linear instance driven in lockstep.
module tb_fc_layer;
  import cnn1d_pkg::*;

  typedef struct packed {
    logic [3:0][11:0] w;
    logic [1:0][11:0] b;
    logic [1:0][11:0] x;
    logic [1:0][11:0] er;
    logic [1:0][11:0] en;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              fc_valid_in;
  logic              fc_ready_out;
  logic              cfg_wr_en;
  logic [2:0]        cfg_addr;
  logic signed [11:0] cfg_data;
  logic signed [11:0] din [0:1];
  logic              r_ready_in, r_valid_out, r_cfg_ready;
  logic              n_ready_in, n_valid_out, n_cfg_ready;
  logic signed [11:0] r_dout [0:1];
  logic signed [11:0] n_dout [0:1];

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl [6];

  always #5 clk = ~clk;

  fc_layer #(.NUM_INPUTS(2), .NUM_OUTPUTS(2), .DATA_WIDTH(12), .FRAC_BITS(9), .ACTIVATION(ACT_RELU)) u_relu (
    .clk(clk), .rst(rst), .fc_ready_in(r_ready_in), .fc_valid_in(fc_valid_in), .fc_data_in(din),
    .fc_ready_out(fc_ready_out), .fc_valid_out(r_valid_out), .fc_data_out(r_dout),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(r_cfg_ready));

  fc_layer #(.NUM_INPUTS(2), .NUM_OUTPUTS(2), .DATA_WIDTH(12), .FRAC_BITS(9), .ACTIVATION(ACT_NONE)) u_none (
    .clk(clk), .rst(rst), .fc_ready_in(n_ready_in), .fc_valid_in(fc_valid_in), .fc_data_in(din),
    .fc_ready_out(fc_ready_out), .fc_valid_out(n_valid_out), .fc_data_out(n_dout),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(n_cfg_ready));

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [11:0] w0, w1, w2, w3, b0, b1, x0, x1, r0, r1, e0, e1);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.b[0] = b0; v.b[1] = b1; v.x[0] = x0; v.x[1] = x1;
    v.er[0] = r0; v.er[1] = r1; v.en[0] = e0; v.en[1] = e1;
    return v;
  endfunction

  // All tasks start and end right after a falling edge.
  task automatic cfg_write(input logic [2:0] a, input logic [11:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic load(input vec_t v);
    for (int k = 0; k < 4; k++) cfg_write(3'(k), v.w[k]);
    cfg_write(3'd4, v.b[0]);
    cfg_write(3'd5, v.b[1]);
  endtask

  // Handshake a vector in, then count edges (handshake edge = 1) until valid_out rises.
  task automatic start_vec(input string tag, input logic [11:0] x0, input logic [11:0] x1);
    int lat;
    chk({tag, "_ready_in"}, 12'(r_ready_in), 12'd1);
    din[0] = x0; din[1] = x1; fc_valid_in = 1'b1;
    @(negedge clk);
    fc_valid_in = 1'b0; cfg_wr_en = 1'b0;
    lat = 1;
    while (!r_valid_out && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 12'(lat), 12'd5);
  endtask

  task automatic check_out(input string tag, input logic [11:0] r0, r1, e0, e1);
    chk({tag, "_relu0"}, r_dout[0], r0);
    chk({tag, "_relu1"}, r_dout[1], r1);
    chk({tag, "_lin0"},  n_dout[0], e0);
    chk({tag, "_lin1"},  n_dout[1], e1);
    chk({tag, "_lin_valid"}, 12'(n_valid_out), 12'd1);
    chk({tag, "_busy"}, 12'(r_ready_in), 12'd0);
  endtask

  task automatic finish_out(input string tag);
    fc_ready_out = 1'b1;
    @(negedge clk);
    fc_ready_out = 1'b0;
    chk({tag, "_valid_drop"}, 12'(r_valid_out), 12'd0);
    chk({tag, "_idle_again"}, 12'(r_ready_in), 12'd1);
  endtask

  task automatic run_vec(input string tag, input logic [11:0] x0, x1, r0, r1, e0, e1);
    start_vec(tag, x0, x1);
    check_out(tag, r0, r1, e0, e1);
    finish_out(tag);
  endtask

  initial begin
    //            w00     w01     w10     w11     b0      b1      x0      x1      relu0   relu1   lin0    lin1
    tbl[0] = mk(12'h200, 12'h200, 12'h200, 12'h200, 12'h000, 12'hE00, 12'h200, 12'h200, 12'h400, 12'h200, 12'h400, 12'h200);
    tbl[1] = mk(12'h200, 12'h200, 12'h200, 12'h200, 12'h000, 12'hE00, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'hE00);
    tbl[2] = mk(12'h400, 12'h400, 12'h400, 12'h400, 12'h000, 12'h000, 12'h400, 12'h400, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF);
    tbl[3] = mk(12'h400, 12'h400, 12'h400, 12'h400, 12'h000, 12'h000, 12'hC00, 12'hC00, 12'h000, 12'h000, 12'h800, 12'h800);
    tbl[4] = mk(12'h200, 12'hE00, 12'h100, 12'h100, 12'h100, 12'h000, 12'h300, 12'h100, 12'h300, 12'h200, 12'h300, 12'h200);
    // -2^-18 must floor to -2^-9, not truncate to zero
    tbl[5] = mk(12'h001, 12'h000, 12'h200, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'hFFF);

    rst = 1'b0; fc_valid_in = 1'b0; fc_ready_out = 1'b0; cfg_wr_en = 1'b0;
    cfg_addr = 3'd0; cfg_data = 12'sd0; din[0] = 12'sd0; din[1] = 12'sd0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 12'(r_valid_out), 12'd0);
    chk("rst_dout0", r_dout[0], 12'h000);
    chk("rst_dout1", n_dout[1], 12'h000);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready_in", 12'(r_ready_in), 12'd1);
    chk("rel_cfg_ready", 12'(r_cfg_ready), 12'd1);

    for (int v = 0; v < 6; v++) begin
      load(tbl[v]);
      run_vec($sformatf("vec%0d", v), tbl[v].x[0], tbl[v].x[1], tbl[v].er[0], tbl[v].er[1], tbl[v].en[0], tbl[v].en[1]);
    end

    // Back-pressure: output held, input and config ignored while stalled.
    load(tbl[0]);
    start_vec("hold", 12'h200, 12'h200);
    for (int c = 0; c < 10; c++) begin
      fc_valid_in = 1'b1; din[0] = 12'h7FF; din[1] = 12'h7FF;
      cfg_wr_en = 1'b1; cfg_addr = 3'(c % 6); cfg_data = 12'h123;
      @(negedge clk);
      chk($sformatf("hold%0d_valid", c), 12'(r_valid_out), 12'd1);
      chk($sformatf("hold%0d_d0", c), r_dout[0], 12'h400);
      chk($sformatf("hold%0d_d1", c), r_dout[1], 12'h200);
      chk($sformatf("hold%0d_rdy", c), 12'(r_ready_in), 12'd0);
      chk($sformatf("hold%0d_cfgrdy", c), 12'(r_cfg_ready), 12'd0);
    end
    fc_valid_in = 1'b0; cfg_wr_en = 1'b0;
    finish_out("hold");
    run_vec("after_hold", 12'h200, 12'h200, 12'h400, 12'h200, 12'h400, 12'h200);

    // Writes during S_MAC and to out-of-range addresses are dropped.
    din[0] = 12'h200; din[1] = 12'h200; fc_valid_in = 1'b1;
    @(negedge clk);
    fc_valid_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cfg_wr_en = 1'b1; cfg_addr = 3'(c); cfg_data = 12'h7FF;
      @(negedge clk);
    end
    cfg_wr_en = 1'b0;
    chk("macwr_valid", 12'(r_valid_out), 12'd1);
    check_out("macwr", 12'h400, 12'h200, 12'h400, 12'h200);
    finish_out("macwr");
    cfg_write(3'd6, 12'h7FF);
    cfg_write(3'd7, 12'h7FF);
    run_vec("oor", 12'h200, 12'h200, 12'h400, 12'h200, 12'h400, 12'h200);

    // Config write in the same cycle as input accept is used by that vector.
    cfg_wr_en = 1'b1; cfg_addr = 3'd4; cfg_data = 12'h200;
    start_vec("samecyc", 12'h200, 12'h200);
    check_out("samecyc", 12'h600, 12'h200, 12'h600, 12'h200);
    finish_out("samecyc");

    // Reset in the second S_MAC cycle clears everything, including coefficients.
    load(tbl[0]);
    din[0] = 12'h200; din[1] = 12'h200; fc_valid_in = 1'b1;
    @(negedge clk);
    fc_valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 12'(r_valid_out), 12'd0);
    chk("midrst_ready", 12'(r_ready_in), 12'd1);
    chk("midrst_cfgrdy", 12'(n_cfg_ready), 12'd1);
    chk("midrst_d0", r_dout[0], 12'h000);
    chk("midrst_d1", n_dout[1], 12'h000);
    rst = 1'b1;
    run_vec("cleared", 12'h200, 12'h200, 12'h000, 12'h000, 12'h000, 12'h000);
    load(tbl[0]);
    run_vec("reload", 12'h200, 12'h200, 12'h400, 12'h200, 12'h400, 12'h200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
